// File: rtl/reservation_station_generic_pkg.sv
// Shared defaults for the generic reservation station and its helpers.
package reservation_station_generic_pkg;

  localparam int RS_DEPTH_DEF   = 16;
  localparam int RS_DATA_W_DEF  = 32;
  localparam int RS_ROB_W_DEF   = 4;
  localparam int RS_OP_W_DEF    = 4;
  localparam int RS_NUM_CDB_DEF = 2;

endpackage

// File: rtl/reservation_station_generic_if.sv
// Dispatch, CDB snoop and issue signals of the reservation station.
interface reservation_station_generic_if #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 4,
  parameter int NUM_CDB = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: dispatch is taken when in_valid && !has_no_vacancy; an issue
  // completes when out_valid && out_ready, and out_* hold while out_ready is low.
  logic                      in_valid;
  logic [OP_W-1:0]           in_op;
  logic [DATA_W-1:0]         in_Vj;
  logic [DATA_W-1:0]         in_Vk;
  logic [ROB_W-1:0]          in_Qj;
  logic [ROB_W-1:0]          in_Qk;
  logic [ROB_W-1:0]          in_dest;
  logic                      has_no_vacancy;
  logic                      has_one_vacancy;
  logic [CNT_W-1:0]          occupancy;
  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic                      out_valid;
  logic                      out_ready;
  logic [OP_W-1:0]           out_op;
  logic [DATA_W-1:0]         out_Vj;
  logic [DATA_W-1:0]         out_Vk;
  logic [ROB_W-1:0]          out_dest;

  modport master (
    output in_valid, in_op, in_Vj, in_Vk, in_Qj, in_Qk, in_dest,
    output cdb_rob_id, cdb_value, out_ready,
    input  has_no_vacancy, has_one_vacancy, occupancy,
    input  out_valid, out_op, out_Vj, out_Vk, out_dest
  );

  modport slave (
    input  in_valid, in_op, in_Vj, in_Vk, in_Qj, in_Qk, in_dest,
    input  cdb_rob_id, cdb_value, out_ready,
    output has_no_vacancy, has_one_vacancy, occupancy,
    output out_valid, out_op, out_Vj, out_Vk, out_dest
  );
endinterface

// File: rtl/reservation_station_generic_age_select.sv
// Oldest-ready picker over an age matrix; older_i[i][j] means j is older than i.
module reservation_station_generic_age_select #(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [IDX_W-1:0]            grant_idx_o,
  output logic                        has_grant_o
);

  always_comb begin
    grant_idx_o = '0;
    has_grant_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_i[i] && !(|(older_i[i] & ready_i))) begin
        grant_idx_o = IDX_W'(i);
        has_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station_generic.sv
// Reservation station: buffers dispatched ops, snoops CDBs, issues oldest ready op.
module reservation_station_generic
  import reservation_station_generic_pkg::*;
#(
  parameter  int DEPTH   = RS_DEPTH_DEF,
  parameter  int DATA_W  = RS_DATA_W_DEF,
  parameter  int ROB_W   = RS_ROB_W_DEF,
  parameter  int OP_W    = RS_OP_W_DEF,
  parameter  int NUM_CDB = RS_NUM_CDB_DEF,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input logic clk_in,
  input logic rst_in,
  input logic flush_input,
  reservation_station_generic_if.slave rs_if
);

  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [OP_W-1:0]             op_q [DEPTH];
  logic [OP_W-1:0]             op_d [DEPTH];
  logic [DATA_W-1:0]           vj_q [DEPTH];
  logic [DATA_W-1:0]           vj_d [DEPTH];
  logic [DATA_W-1:0]           vk_q [DEPTH];
  logic [DATA_W-1:0]           vk_d [DEPTH];
  logic [ROB_W-1:0]            qj_q [DEPTH];
  logic [ROB_W-1:0]            qj_d [DEPTH];
  logic [ROB_W-1:0]            qk_q [DEPTH];
  logic [ROB_W-1:0]            qk_d [DEPTH];
  logic [ROB_W-1:0]            dest_q [DEPTH];
  logic [ROB_W-1:0]            dest_d [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [CNT_W-1:0]            occ_q, occ_d;

  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_vj_q, out_vj_d;
  logic [DATA_W-1:0] out_vk_q, out_vk_d;
  logic [ROB_W-1:0]  out_dest_q, out_dest_d;

  logic [ROB_W-1:0]  cdb_tag [NUM_CDB];
  logic [DATA_W-1:0] cdb_val [NUM_CDB];
  logic [DEPTH-1:0]  ready;
  logic [IDX_W-1:0]  grant_idx, free_idx;
  logic              has_grant, load, issue, accept, no_vac;
  logic [DATA_W-1:0] fwd_vj, fwd_vk;
  logic [ROB_W-1:0]  fwd_qj, fwd_qk;

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag[k] = rs_if.cdb_rob_id[k*ROB_W +: ROB_W];
      cdb_val[k] = rs_if.cdb_value[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  reservation_station_generic_age_select #(.DEPTH(DEPTH)) u_age_select (
    .ready_i     (ready),
    .older_i     (older_q),
    .grant_idx_o (grant_idx),
    .has_grant_o (has_grant)
  );

  assign no_vac = (occ_q == CNT_W'(DEPTH));
  assign load   = !out_valid_q || rs_if.out_ready;
  assign issue  = load && has_grant;
  assign accept = rs_if.in_valid && !no_vac;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Descending channel scan so the lowest matching channel wins.
  always_comb begin
    fwd_vj = rs_if.in_Vj;
    fwd_qj = rs_if.in_Qj;
    fwd_vk = rs_if.in_Vk;
    fwd_qk = rs_if.in_Qk;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_tag[k] != '0 && rs_if.in_Qj == cdb_tag[k]) begin
        fwd_vj = cdb_val[k];
        fwd_qj = '0;
      end
      if (cdb_tag[k] != '0 && rs_if.in_Qk == cdb_tag[k]) begin
        fwd_vk = cdb_val[k];
        fwd_qk = '0;
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    dest_d  = dest_q;
    older_d = older_q;
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (busy_q[e] && cdb_tag[k] != '0 && qj_q[e] == cdb_tag[k]) begin
          vj_d[e] = cdb_val[k];
          qj_d[e] = '0;
        end
        if (busy_q[e] && cdb_tag[k] != '0 && qk_q[e] == cdb_tag[k]) begin
          vk_d[e] = cdb_val[k];
          qk_d[e] = '0;
        end
      end
    end
    if (issue) busy_d[grant_idx] = 1'b0;
    // A new entry is younger than every entry busy at the start of the cycle.
    if (accept) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = rs_if.in_op;
      vj_d[free_idx]   = fwd_vj;
      vk_d[free_idx]   = fwd_vk;
      qj_d[free_idx]   = fwd_qj;
      qk_d[free_idx]   = fwd_qk;
      dest_d[free_idx] = rs_if.in_dest;
      for (int j = 0; j < DEPTH; j++) older_d[free_idx][j] = busy_q[j];
      for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = 1'b0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, issue})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_vj_d    = out_vj_q;
    out_vk_d    = out_vk_q;
    out_dest_d  = out_dest_q;
    if (load) begin
      out_valid_d = has_grant;
      if (has_grant) begin
        out_op_d   = op_q[grant_idx];
        out_vj_d   = vj_q[grant_idx];
        out_vk_d   = vk_q[grant_idx];
        out_dest_d = dest_q[grant_idx];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_input) begin
      busy_q      <= '0;
      older_q     <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_vj_q    <= '0;
      out_vk_q    <= '0;
      out_dest_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      older_q     <= older_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_vj_q    <= out_vj_d;
      out_vk_q    <= out_vk_d;
      out_dest_q  <= out_dest_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
    end
  end

  assign rs_if.has_no_vacancy  = no_vac;
  assign rs_if.has_one_vacancy = (occ_q == CNT_W'(DEPTH - 1));
  assign rs_if.occupancy       = occ_q;
  assign rs_if.out_valid       = out_valid_q;
  assign rs_if.out_op          = out_op_q;
  assign rs_if.out_Vj          = out_vj_q;
  assign rs_if.out_Vk          = out_vk_q;
  assign rs_if.out_dest        = out_dest_q;

endmodule

// File: tb/tb_reservation_station_generic.sv
// Directed bench for the reservation station: age order, wakeup, backpressure, full, flush.
module tb_reservation_station_generic;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 4;
  localparam int NUM_CDB = 2;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;
  logic [ROB_W-1:0] exp_q[$];

  reservation_station_generic_if #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) bus ();

  reservation_station_generic #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .flush_input (flush),
    .rs_if       (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic dispatch(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                          input logic [DATA_W-1:0] vk, input logic [ROB_W-1:0] qj,
                          input logic [ROB_W-1:0] qk, input logic [ROB_W-1:0] dest);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_Vj    = vj;
    bus.in_Vk    = vk;
    bus.in_Qj    = qj;
    bus.in_Qk    = qk;
    bus.in_dest  = dest;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic cdb_set(input int ch, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val);
    bus.cdb_rob_id = '0;
    bus.cdb_value  = '0;
    bus.cdb_rob_id[ch*ROB_W +: ROB_W]   = tag;
    bus.cdb_value[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic cdb_idle();
    bus.cdb_rob_id = '0;
    bus.cdb_value  = '0;
  endtask

  // Scoreboard: compare the issued op against the next expected destination.
  task automatic expect_issue(input string tag);
    logic [ROB_W-1:0] exp_dest;
    exp_dest = exp_q.pop_front();
    check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
    check_eq({tag, "_dest"}, bus.out_dest, exp_dest);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_Vj    = '0;
    bus.in_Vk    = '0;
    bus.in_Qj    = '0;
    bus.in_Qk    = '0;
    bus.in_dest  = '0;
    bus.out_ready = 1'b1;
    cdb_idle();
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_op", bus.out_op, 0);
    check_eq("rst_out_vj", bus.out_Vj, 0);
    check_eq("rst_out_vk", bus.out_Vk, 0);
    check_eq("rst_out_dest", bus.out_dest, 0);
    check_eq("rst_occ", bus.occupancy, 0);
    check_eq("rst_no_vac", bus.has_no_vacancy, 1'b0);
    check_eq("rst_one_vac", bus.has_one_vacancy, 1'b0);

    // Age order: younger ready B overtakes waiting A
    dispatch(4'd1, 32'h0, 32'h22, 4'd5, 4'd0, 4'd3);
    dispatch(4'd2, 32'h11, 32'h12, 4'd0, 4'd0, 4'd4);
    check_eq("age_occ2", bus.occupancy, 2);
    check_eq("age_idle", bus.out_valid, 1'b0);
    tick();
    exp_q.push_back(4'd4);
    expect_issue("age_b");
    check_eq("age_b_vj", bus.out_Vj, 32'h11);
    check_eq("age_occ1", bus.occupancy, 1);
    cdb_set(1, 4'd5, 32'h10);
    tick();
    cdb_idle();
    check_eq("age_gap", bus.out_valid, 1'b0);
    tick();
    exp_q.push_back(4'd3);
    expect_issue("age_a");
    check_eq("age_a_vj", bus.out_Vj, 32'h10);
    check_eq("age_a_vk", bus.out_Vk, 32'h22);
    check_eq("age_a_op", bus.out_op, 1);
    check_eq("age_occ0", bus.occupancy, 0);
    tick();

    // Oldest-first after a shared wakeup
    dispatch(4'd6, 32'h0, 32'h66, 4'd7, 4'd0, 4'd6);
    dispatch(4'd7, 32'h88, 32'h0, 4'd0, 4'd7, 4'd8);
    cdb_set(0, 4'd7, 32'h77);
    tick();
    cdb_idle();
    tick();
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd8);
    expect_issue("old_c");
    check_eq("old_c_vj", bus.out_Vj, 32'h77);
    tick();
    expect_issue("old_d");
    check_eq("old_d_vk", bus.out_Vk, 32'h77);
    tick();
    check_eq("old_drain", bus.out_valid, 1'b0);

    // Backpressure
    bus.out_ready = 1'b0;
    dispatch(4'd3, 32'h1, 32'h2, 4'd0, 4'd0, 4'd9);
    dispatch(4'd4, 32'h3, 32'h4, 4'd0, 4'd0, 4'd10);
    check_eq("bp_occ_swap", bus.occupancy, 1);
    dispatch(4'd5, 32'h5, 32'h6, 4'd0, 4'd0, 4'd11);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold_valid", bus.out_valid, 1'b1);
      check_eq("bp_hold_dest", bus.out_dest, 9);
      check_eq("bp_hold_vj", bus.out_Vj, 32'h1);
      check_eq("bp_hold_occ", bus.occupancy, 2);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    exp_q.push_back(4'd10);
    exp_q.push_back(4'd11);
    expect_issue("bp_f");
    check_eq("bp_occ1", bus.occupancy, 1);
    tick();
    expect_issue("bp_g");
    check_eq("bp_occ0", bus.occupancy, 0);
    tick();
    check_eq("bp_drain", bus.out_valid, 1'b0);

    // Full, then one issue, then flush with three entries left
    dispatch(4'd1, 32'h0, 32'h0, 4'd13, 4'd0, 4'd1);
    dispatch(4'd1, 32'h0, 32'h0, 4'd12, 4'd0, 4'd2);
    dispatch(4'd1, 32'h0, 32'h0, 4'd12, 4'd0, 4'd3);
    check_eq("full_one_vac", bus.has_one_vacancy, 1'b1);
    dispatch(4'd1, 32'h0, 32'h0, 4'd12, 4'd0, 4'd4);
    check_eq("full_occ4", bus.occupancy, 4);
    check_eq("full_no_vac", bus.has_no_vacancy, 1'b1);
    dispatch(4'd2, 32'h1, 32'h1, 4'd0, 4'd0, 4'd5);
    check_eq("full_ignored_occ", bus.occupancy, 4);
    tick();
    check_eq("full_ignored_valid", bus.out_valid, 1'b0);
    cdb_set(0, 4'd13, 32'h5);
    tick();
    cdb_idle();
    tick();
    exp_q.push_back(4'd1);
    expect_issue("full_issue");
    check_eq("full_occ3", bus.occupancy, 3);
    check_eq("full_one_vac2", bus.has_one_vacancy, 1'b1);
    check_eq("full_no_vac2", bus.has_no_vacancy, 1'b0);
    flush = 1'b1;
    dispatch(4'd2, 32'h1, 32'h1, 4'd0, 4'd0, 4'd6);
    flush = 1'b0;
    check_eq("flush_occ", bus.occupancy, 0);
    check_eq("flush_valid", bus.out_valid, 1'b0);
    check_eq("flush_dest", bus.out_dest, 0);
    check_eq("flush_vj", bus.out_Vj, 0);
    cdb_set(0, 4'd12, 32'h7);
    tick();
    cdb_idle();
    tick();
    check_eq("flush_no_issue", bus.out_valid, 1'b0);
    check_eq("flush_occ_after", bus.occupancy, 0);

    // Same-cycle CDB forwarding at dispatch
    cdb_set(0, 4'd9, 32'hABCD);
    dispatch(4'd5, 32'h5, 32'h0, 4'd0, 4'd9, 4'd2);
    cdb_idle();
    tick();
    exp_q.push_back(4'd2);
    expect_issue("fwd");
    check_eq("fwd_vk", bus.out_Vk, 32'hABCD);
    check_eq("fwd_vj", bus.out_Vj, 32'h5);
    check_eq("fwd_op", bus.out_op, 5);
    tick();
    check_eq("fwd_drain", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
